// File: rtl/montgomery_precompute.sv
// Montgomery constant generator: rmodm = 2^W mod M, r2modm = 2^(2W) mod M.
// One modular doubling per cycle; 2*WIDTH doublings per modulus.
module montgomery_precompute #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] rmodm,
    output logic [WIDTH-1:0] r2modm,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(2 * WIDTH) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] INIT   = 2'd1;
    localparam logic [1:0] DOUBLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] v;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   mx;
    logic [WIDTH:0]   red_w;
    logic [WIDTH-1:0] red;
    logic             unused_red_msb;

    // v < M keeps 2v < 2M, so a single conditional subtract suffices
    always_comb begin
        t     = {v, 1'b0};
        mx    = {1'b0, m_reg};
        red_w = (t >= mx) ? (t - mx) : t;
        red   = red_w[WIDTH-1:0];
    end

    assign unused_red_msb = red_w[WIDTH];

    assign busy = (state == INIT) || (state == DOUBLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            m_reg  <= '0;
            v      <= '0;
            cnt    <= '0;
            rmodm  <= '0;
            r2modm <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg <= in_m;
                        err   <= 1'b0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    if (m_reg == '0) begin
                        err    <= 1'b1;
                        rmodm  <= '0;
                        r2modm <= '0;
                        state  <= DONE;
                    end else begin
                        v     <= (m_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
                        cnt   <= '0;
                        state <= DOUBLE;
                    end
                end
                DOUBLE: begin
                    v   <= red;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        rmodm <= red;
                    end
                    if (cnt == CW'(2 * WIDTH - 1)) begin
                        r2modm <= red;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_precompute.sv
// Directed bench for montgomery_precompute at WIDTH=8 plus a
// WIDTH=512 instance checked against a wide-modulo reference.
module tb_montgomery_precompute;

    logic         clk = 1'b0;
    logic         reset;

    logic         start8;
    logic [7:0]   in_m8;
    logic [7:0]   rmodm8, r2modm8;
    logic         busy8, done8, err8;

    logic         start5;
    logic [511:0] in_m5;
    logic [511:0] rmodm5, r2modm5;
    logic         busy5, done5, err5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    montgomery_precompute #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start8),
        .in_m   (in_m8),
        .rmodm  (rmodm8),
        .r2modm (r2modm8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8)
    );

    montgomery_precompute #(.WIDTH(512)) dut512 (
        .clk    (clk),
        .reset  (reset),
        .start  (start5),
        .in_m   (in_m5),
        .rmodm  (rmodm5),
        .r2modm (r2modm5),
        .busy   (busy5),
        .done   (done5),
        .err    (err5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start with modulus m, wait for done, check latency and results
    task automatic run8(input string tag, input logic [7:0] m,
                        input int lat, input logic [7:0] er,
                        input logic [7:0] er2, input logic ee);
        int n;
        in_m8  = m;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 512'(n), 512'(lat));
        check({tag, "_rmodm"}, 512'(rmodm8), 512'(er));
        check({tag, "_r2modm"}, 512'(r2modm8), 512'(er2));
        check({tag, "_err"}, 512'(err8), 512'(ee));
        check({tag, "_busy"}, 512'(busy8), 512'(0));
    endtask

    initial begin
        logic [1024:0] p1, p2, mm;
        logic [511:0]  m;
        logic [511:0]  er, er2;
        int            n;

        reset  = 1'b1;
        start8 = 1'b0;
        in_m8  = '0;
        start5 = 1'b0;
        in_m5  = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_rmodm", 512'(rmodm8), 512'(0));
        check("rst_r2modm", 512'(r2modm8), 512'(0));
        check("rst_busy", 512'(busy8), 512'(0));
        check("rst_done", 512'(done8), 512'(0));
        check("rst_err", 512'(err8), 512'(0));

        run8("m13", 8'd13, 18, 8'd9, 8'd3, 1'b0);
        run8("m255", 8'd255, 18, 8'd1, 8'd1, 1'b0);
        run8("m1", 8'd1, 18, 8'd0, 8'd0, 1'b0);
        run8("m200", 8'd200, 18, 8'd56, 8'd136, 1'b0);
        run8("m254", 8'd254, 18, 8'd2, 8'd4, 1'b0);
        run8("m0", 8'd0, 2, 8'd0, 8'd0, 1'b1);
        run8("m13b", 8'd13, 18, 8'd9, 8'd3, 1'b0);
        run8("m2", 8'd2, 18, 8'd0, 8'd0, 1'b0);

        // abort 5 cycles into DOUBLE
        run8("m11a", 8'd11, 18, 8'd3, 8'd9, 1'b0);
        in_m8  = 8'd13;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        repeat (5) step();
        check("mid_busy", 512'(busy8), 512'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 512'(busy8), 512'(0));
        check("abort_done", 512'(done8), 512'(0));
        check("abort_rmodm", 512'(rmodm8), 512'(0));
        check("abort_r2modm", 512'(r2modm8), 512'(0));
        step();
        check("abort_idle", 512'(busy8), 512'(0));
        run8("m11", 8'd11, 18, 8'd3, 8'd9, 1'b0);

        // reset beats a simultaneous start
        in_m8  = 8'd13;
        start8 = 1'b1;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        start8 = 1'b0;
        check("rst_vs_start_busy", 512'(busy8), 512'(0));
        step();
        check("rst_vs_start_idle", 512'(busy8), 512'(0));

        // start and in_m changes while busy are ignored
        in_m8  = 8'd13;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1;
        repeat (4) begin
            in_m8  = 8'd7;
            start8 = 1'b1;
            step();
            n++;
        end
        start8 = 1'b0;
        in_m8  = 8'd5;
        while (!done8 && n < 100) begin
            step();
            n++;
        end
        check("busy_ign_lat", 512'(n), 512'(18));
        check("busy_ign_rmodm", 512'(rmodm8), 512'(9));
        check("busy_ign_r2modm", 512'(r2modm8), 512'(3));
        repeat (3) step();
        check("done_hold", 512'(done8), 512'(1));
        check("done_hold_r", 512'(rmodm8), 512'(9));

        // WIDTH=512 against wide-modulo reference
        for (int it = 0; it < 12; it++) begin
            for (int w = 0; w < 16; w++) m[w*32 +: 32] = $urandom;
            if (it == 0) m = '1;
            if (it == 1) m = 512'd3;
            if (it == 2) m[511] = 1'b1;
            m[0] = 1'b1;
            mm = {513'b0, m};
            p1 = '0;
            p1[512] = 1'b1;
            p2 = '0;
            p2[1024] = 1'b1;
            p1 = p1 % mm;
            p2 = p2 % mm;
            er  = p1[511:0];
            er2 = p2[511:0];
            in_m5  = m;
            start5 = 1'b1;
            step();
            start5 = 1'b0;
            in_m5  = '0;
            n = 1;
            while (!done5 && n < 1100) begin
                step();
                n++;
            end
            check($sformatf("w512_%0d_lat", it), 512'(n), 512'(1026));
            check($sformatf("w512_%0d_rmodm", it), rmodm5, er);
            check($sformatf("w512_%0d_r2modm", it), r2modm5, er2);
            check($sformatf("w512_%0d_err", it), 512'(err5), 512'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
